mmio_uart_fifo: RTL

Memory-mapped UART controller for the Riscv151 core. It sits between the CPU data-memory bus and the existing uart_receiver and uart_transmitter modules. Parametrised RX and TX FIFOs decouple the core from the serial rate, and the block adds sticky error flags and a free-running cycle counter. It replaces the direct single-byte ready/valid hookup with buffered, status-polled I/O.

---
 rtl/uart_mmio_pkg.sv | 35 +++
 rtl/mmio_uart_fifo_sync_fifo.sv | 56 +++++
 rtl/mmio_uart_fifo.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
// Register indices, STATUS layout and small helpers shared by the MMIO UART block.
// The IRQ_MASK index is only decoded when UART_IRQ_EN is defined.
package uart_mmio_pkg;

    localparam logic [2:0] REG_STATUS    = 3'd0;
    localparam logic [2:0] REG_RX_DATA   = 3'd1;
    localparam logic [2:0] REG_TX_DATA   = 3'd2;
    localparam logic [2:0] REG_CLEAR     = 3'd3;
    localparam logic [2:0] REG_CYCLE_CNT = 3'd4;
    localparam logic [2:0] REG_IRQ_MASK  = 3'd5;

    localparam int ST_TX_SPACE   = 0;
    localparam int ST_RX_AVAIL   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_TX_DROP    = 3;
    localparam int ST_RX_CNT_LSB = 8;
    localparam int ST_TX_CNT_LSB = 16;

    typedef struct packed {
        logic [7:0] rsvd_hi;
        logic [7:0] tx_cnt;
        logic [7:0] rx_cnt;
        logic [3:0] rsvd_lo;
        logic       tx_drop;
        logic       rx_overrun;
        logic       rx_avail;
        logic       tx_space;
    } status_t;

    // FIFO occupancy fields are 8 bits wide regardless of the configured depth.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/mmio_uart_fifo_sync_fifo.sv
// Single-clock circular FIFO with a combinational head; push is refused when full
// and pop when empty, both judged on the occupancy before the edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_fifo.sv
// Memory-mapped UART front end: buffered RX/TX FIFOs, sticky error flags and a cycle counter.
// Define UART_IRQ_EN to add the irq output and the IRQ_MASK register at index 5.
module mmio_uart_fifo
    import uart_mmio_pkg::*;
#(
    parameter int RX_DEPTH   = 16,
    parameter int TX_DEPTH   = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AWIDTH     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [31:0]           wdata,
    input  logic                  we,
    input  logic                  re,
    output logic [31:0]           rdata,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
`ifdef UART_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int TXAW = $clog2(TX_DEPTH);

    logic [2:0]            w_word;
    logic                  w_rd_rx;
    logic                  w_wr_tx;
    logic                  w_wr_clr;
    logic [DATA_WIDTH-1:0] w_rx_dout;
    logic [DATA_WIDTH-1:0] w_rx_head;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic [RXAW:0]         w_rx_count;
    logic [DATA_WIDTH-1:0] w_tx_dout;
    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [TXAW:0]         w_tx_count;
    logic                  w_rx_push;
    logic                  w_tx_pop;
    status_t               w_status;
    logic [31:0]           w_rd_val;
    logic                  w_unused_ok;

    logic [31:0]           r_rdata;
    logic [31:0]           r_cyc;
    logic                  r_rx_overrun;
    logic                  r_tx_drop;

    assign w_word   = addr[4:2];
    assign w_rd_rx  = re & (w_word == REG_RX_DATA);
    assign w_wr_tx  = we & (w_word == REG_TX_DATA);
    assign w_wr_clr = we & (w_word == REG_CLEAR);

    // Byte lane and low address bits are not decoded.
    assign w_unused_ok = &{1'b0, addr[1:0], wdata[31:DATA_WIDTH]};

    // rx_ready is forced low while reset is held so the receiver sees no acceptance.
    assign rx_ready  = rst_n & ~w_rx_full;
    assign w_rx_push = rx_valid & rx_ready;
    assign w_rx_head = w_rx_empty ? '0 : w_rx_dout;

    assign tx_valid  = ~w_tx_empty;
    assign tx_data   = w_tx_empty ? '0 : w_tx_dout;
    assign w_tx_pop  = tx_valid & tx_ready;

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_rx_push),
        .din   (rx_data),
        .pop   (w_rd_rx & ~w_rx_empty),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_wr_tx),
        .din   (wdata[DATA_WIDTH-1:0]),
        .pop   (w_tx_pop),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

    // A new error event in the same cycle as CLEAR wins, so it is never silently lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_overrun <= 1'b0;
            r_tx_drop    <= 1'b0;
            r_cyc        <= '0;
        end else begin
            if (rx_valid & w_rx_full) r_rx_overrun <= 1'b1;
            else if (w_wr_clr)        r_rx_overrun <= 1'b0;
            if (w_wr_tx & w_tx_full)  r_tx_drop <= 1'b1;
            else if (w_wr_clr)        r_tx_drop <= 1'b0;
            r_cyc <= w_wr_clr ? '0 : r_cyc + 32'd1;
        end
    end

    always_comb begin
        w_status            = '0;
        w_status.tx_space   = ~w_tx_full;
        w_status.rx_avail   = ~w_rx_empty;
        w_status.rx_overrun = r_rx_overrun;
        w_status.tx_drop    = r_tx_drop;
        w_status.rx_cnt     = sat8(32'(w_rx_count));
        w_status.tx_cnt     = sat8(32'(w_tx_count));
    end

`ifdef UART_IRQ_EN
    logic [1:0] r_irq_mask;
    logic       r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (we && (w_word == REG_IRQ_MASK)) r_irq_mask <= wdata[1:0];
            r_irq <= (r_irq_mask[0] & w_status.tx_space) | (r_irq_mask[1] & w_status.rx_avail);
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        w_rd_val = '0;
        case (w_word)
            REG_STATUS:    w_rd_val = w_status;
            REG_RX_DATA:   w_rd_val = 32'(w_rx_head);
            REG_CYCLE_CNT: w_rd_val = r_cyc;
`ifdef UART_IRQ_EN
            REG_IRQ_MASK:  w_rd_val = {30'd0, r_irq_mask};
`endif
            default:       w_rd_val = '0;
        endcase
    end

    // Load data is captured on the re edge and held until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  r_rdata <= '0;
        else if (re) r_rdata <= w_rd_val;
    end

    assign rdata = r_rdata;

endmodule
